mem_stage_dport: RTL and testbench
==================================

// Module: mem_stage_dport
// PURPOSE
//  MEM-stage data-memory port of the pipelined RV32I core. Consumes EX/MEM loads/stores and runs the dmem read/write handshake.
//  While an access is outstanding it stalls the pipeline.
//  Aligns and sign/zero-extends load data per mem_rdatamux select (lw/lb/lbu/lh/lhu) and builds store byte-enables/data.
//  Its result feeds the MEM/WB register and the forward mux paths.
// PARAMETERS
//  TIMEOUT_CYCLES  64  max ACCESS cycles without dmem_resp before the access is abandoned (>=2)
//  CNT_W           7   width of wait counter; must hold TIMEOUT_CYCLES
// PORTS
//  clk          in   1   clock, all state on rising edge
//  rst          in   1   asynchronous, active-low reset
//  req_valid    in   1   EX/MEM holds a valid instruction
//  req_load     in   1   instruction is a load
//  req_store    in   1   instruction is a store (load and store never both 1)
//  req_flush    in   1   squash the instruction in EX/MEM (honoured only in IDLE)
//  req_addr     in   32  effective address (alu_out)
//  req_wdata    in   32  store data (rs2 after forward3mux)
//  req_ldsel    in   4   mem_rdatamux_sel_t: lw=3, lb=5, lbu=6, lh=7, lhu=8
//  req_stfunct3 in   3   store width: 000 sb, 001 sh, 010 sw
//  dmem_read    out  1   read request, registered
//  dmem_write   out  1   write request, registered
//  dmem_address out  32  {addr[31:2],2'b00}
//  dmem_wdata   out  32  lane-replicated store data
//  dmem_mbe     out  4   store byte enables
//  dmem_resp    in   1   access complete, one-cycle pulse
//  dmem_rdata   in   32  read data, valid with dmem_resp
//  stall        out  1   freeze IF..MEM stages
//  rsp_valid    out  1   1-cycle pulse: access finished, load_data valid
//  load_data    out  32  aligned/extended load result; held until next rsp_valid
//  timeout_err  out  1   1-cycle pulse with rsp_valid when the watchdog fired
//  misalign     out  1   1-cycle pulse with rsp_valid on misaligned access (MISALIGN_CHK_EN only)
// BEHAVIOUR
//  Reset: state=IDLE; all outputs and internal registers 0.
//  FSM IDLE -> ACCESS -> DONE -> IDLE.
//  - IDLE: go = req_valid & (req_load|req_store) & ~req_flush.
//    - stall = go, combinational.
//    - On go: capture addr, wdata, ldsel, funct3, and load/store; compute mbe/wdata; go to ACCESS.
//    - On a non-mem or flushed request: remain IDLE, stall=0.
//  - ACCESS: dmem_read or dmem_write = 1 and stall = 1.
//    - Address, wdata and mbe are stable for the whole state.
//    - Wait counter counts up from 0.
//    - dmem_resp=1: latch the aligned result into load_data (load only; stores leave load_data unchanged); go to DONE.
//    - Counter reaches TIMEOUT_CYCLES-1 with no resp: load_data=0, timeout_err=1 for the DONE cycle; go to DONE.
//    - Flush is ignored in ACCESS.
//  - DONE: dmem_read/write=0, stall=0, rsp_valid=1. Pipeline advances at the end of this cycle.
//    - req_* is ignored in DONE. Next state is IDLE.
//  Latency: with resp in the first ACCESS cycle, stall is high for 2 cycles and rsp_valid rises in cycle 3.
//  Load align (off=addr[1:0]):
//  - lb/lbu: byte rdata[8*off+:8], sign/zero-extended.
//  - lh/lhu: half rdata[16*addr[1]+:16], extended.
//  - lw: rdata. Unknown ldsel: 0.
//  Store:
//  - sb: mbe=4'b0001<<off, wdata={4{d[7:0]}}.
//  - sh: mbe=4'b0011<<(2*addr[1]), wdata={2{d[15:0]}}.
//  - sw: mbe=4'hF, wdata=d. Other funct3: mbe=0.
//  Loads drive mbe=4'hF.
//  Async reset asserted mid-ACCESS: immediately IDLE, dmem_read/write drop; a late dmem_resp is ignored.
// CONFIGURATION
//  MISALIGN_CHK_EN defined:
//  - Misaligned = lh/lhu/sh with addr[0]=1, or lw/sw with addr[1:0]!=0.
//  - On go in IDLE, a misaligned access skips ACCESS and goes IDLE->DONE: no dmem request, load_data=0, misalign=1 with rsp_valid.
//  MISALIGN_CHK_EN undefined:
//  - misalign tied 0. Low address bits beyond the access width are ignored and the access proceeds.
// TESTING
//  1. lw addr=0x100, resp after 3 ACCESS cycles, rdata=0xDEADBEEF -> dmem_address=0x100, stall high 4 cycles, rsp_valid then load_data=0xDEADBEEF.
//  2. lb addr=0x203, rdata=0x80112233 -> load_data=0xFFFFFF80; lbu same -> 0x00000080; lhu addr=0x202 -> 0x00008011.
//  3. sb addr=0x301 d=0x000000A5 -> mbe=4'b0010, wdata=0xA5A5A5A5; sh addr=0x302 d=0x1234 -> mbe=4'b1100, wdata=0x12341234.
//  4. lw, dmem_resp never asserted -> read held TIMEOUT_CYCLES cycles; then rsp_valid=timeout_err=1, load_data=0, stall=0.
//  5. rst low during ACCESS, then late resp -> all outputs 0 at once, IDLE; resp produces no rsp_valid. Flush in IDLE -> no request, stall=0.
//  6. MISALIGN_CHK_EN, lw addr=0x102 -> no dmem_read, rsp_valid=misalign=1 on the 2nd cycle. Undefined: read at 0x100.

Source files
------------

// File: rtl/mem_stage_dport_if.sv
// Request, data-memory and result signals of the MEM-stage data port.
//   req_*      : EX/MEM instruction presented to the port
//   dmem_*     : data-memory read/write handshake
//   stall      : freeze IF..MEM while an access is in progress
//   rsp_valid  : access finished, load_data valid
//   load_data  : aligned/extended load result
//   timeout_err: watchdog abandoned the access
//   misalign   : misaligned access rejected (misalign checking builds only)
// slave modport is the port itself; master is the pipeline/memory side.
interface mem_stage_dport_if;
  logic        req_valid;
  logic        req_load;
  logic        req_store;
  logic        req_flush;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_ldsel;
  logic [2:0]  req_stfunct3;
  logic        dmem_read;
  logic        dmem_write;
  logic [31:0] dmem_address;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_mbe;
  logic        dmem_resp;
  logic [31:0] dmem_rdata;
  logic        stall;
  logic        rsp_valid;
  logic [31:0] load_data;
  logic        timeout_err;
  logic        misalign;

  modport slave (
    input  req_valid, req_load, req_store, req_flush, req_addr, req_wdata,
           req_ldsel, req_stfunct3, dmem_resp, dmem_rdata,
    output dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_mbe,
           stall, rsp_valid, load_data, timeout_err, misalign
  );

  modport master (
    output req_valid, req_load, req_store, req_flush, req_addr, req_wdata,
           req_ldsel, req_stfunct3, dmem_resp, dmem_rdata,
    input  dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_mbe,
           stall, rsp_valid, load_data, timeout_err, misalign
  );
endinterface

// File: rtl/mem_stage_dport.sv
// MEM-stage data-memory port of the pipelined RV32I core.
// Takes loads/stores from EX/MEM, runs the dmem handshake (IDLE -> ACCESS ->
// DONE), stalls the pipeline while the access is outstanding, aligns and
// extends load data and builds store byte-enables / lane-replicated data.
// Ports:
//   clk  : clock, all state on the rising edge
//   rst  : asynchronous active-low reset
//   bus  : mem_stage_dport_if.slave (request, dmem handshake, result)
// Optional feature macro: MISALIGN_CHK_EN -- when defined, misaligned
// half/word accesses skip the memory and finish with misalign=1.
module mem_stage_dport #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7
) (
  input  logic              clk,
  input  logic              rst,
  mem_stage_dport_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t            state_r;
  state_t            state_next_s;
  logic [CNT_W-1:0]  cnt_r;
  logic              go_s;
  logic              timeout_s;
  logic              misalign_s;
  logic              is_load_r;
  logic [1:0]        off_r;
  logic [3:0]        ldsel_r;
  logic              dmem_read_r;
  logic              dmem_write_r;
  logic [31:0]       dmem_address_r;
  logic [31:0]       dmem_wdata_r;
  logic [3:0]        dmem_mbe_r;
  logic              rsp_valid_r;
  logic [31:0]       load_data_r;
  logic              timeout_err_r;

  // Select the addressed byte/half from the read word and extend it.
  function automatic logic [31:0] align_load(input logic [3:0] sel,
                                             input logic [1:0] off,
                                             input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    b = rd[8*off +: 8];
    h = off[1] ? rd[31:16] : rd[15:0];
    case (sel)
      4'd3:    align_load = rd;
      4'd5:    align_load = {{24{b[7]}}, b};
      4'd6:    align_load = {24'h000000, b};
      4'd7:    align_load = {{16{h[15]}}, h};
      4'd8:    align_load = {16'h0000, h};
      default: align_load = 32'h0000_0000;
    endcase
  endfunction

  // Byte enables: loads read the whole word; stores enable their lanes.
  function automatic logic [3:0] build_mbe(input logic ld,
                                           input logic [2:0] f3,
                                           input logic [1:0] off);
    if (ld) begin
      build_mbe = 4'hF;
    end else begin
      case (f3)
        3'b000:  build_mbe = 4'b0001 << off;
        3'b001:  build_mbe = 4'b0011 << {off[1], 1'b0};
        3'b010:  build_mbe = 4'hF;
        default: build_mbe = 4'h0;
      endcase
    end
  endfunction

  // Store data is replicated across lanes so the enables pick the slot.
  function automatic logic [31:0] build_wdata(input logic [2:0] f3,
                                              input logic [31:0] d);
    case (f3)
      3'b000:  build_wdata = {4{d[7:0]}};
      3'b001:  build_wdata = {2{d[15:0]}};
      default: build_wdata = d;
    endcase
  endfunction

`ifdef MISALIGN_CHK_EN
  // Half accesses need addr[0]=0, word accesses need addr[1:0]=0.
  function automatic logic is_misaligned(input logic ld,
                                         input logic [3:0] sel,
                                         input logic [2:0] f3,
                                         input logic [1:0] off);
    logic half_s;
    logic word_s;
    half_s = ld ? ((sel == 4'd7) || (sel == 4'd8)) : (f3 == 3'b001);
    word_s = ld ? (sel == 4'd3) : (f3 == 3'b010);
    is_misaligned = (half_s & off[0]) | (word_s & (off != 2'b00));
  endfunction

  logic misalign_r;

  assign misalign_s   = is_misaligned(bus.req_load, bus.req_ldsel,
                                      bus.req_stfunct3, bus.req_addr[1:0]);
  assign bus.misalign = misalign_r;

  // Misalign flag pulses together with rsp_valid in the DONE cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      misalign_r <= 1'b0;
    end else begin
      misalign_r <= go_s & misalign_s;
    end
  end
`else
  assign misalign_s   = 1'b0;
  assign bus.misalign = 1'b0;
`endif

  // Next-state logic; flush is only looked at in IDLE.
  always_comb begin
    state_next_s = state_r;
    go_s         = 1'b0;
    timeout_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        go_s = bus.req_valid & (bus.req_load | bus.req_store) & ~bus.req_flush;
        if (go_s) begin
          if (misalign_s) begin
            state_next_s = ST_DONE;
          end else begin
            state_next_s = ST_ACCESS;
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (bus.dmem_resp) begin
          state_next_s = ST_DONE;
        end else if (cnt_r == TMO_LAST) begin
          timeout_s    = 1'b1;
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_ACCESS;
        end
      end
      ST_DONE: state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State register and ACCESS wait counter (cleared outside ACCESS).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_next_s;
      if (state_r == ST_ACCESS) begin
        cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        cnt_r <= {CNT_W{1'b0}};
      end
    end
  end

  // Request capture, dmem drive, and result registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      is_load_r      <= 1'b0;
      off_r          <= 2'b00;
      ldsel_r        <= 4'h0;
      dmem_read_r    <= 1'b0;
      dmem_write_r   <= 1'b0;
      dmem_address_r <= 32'h0000_0000;
      dmem_wdata_r   <= 32'h0000_0000;
      dmem_mbe_r     <= 4'h0;
      load_data_r    <= 32'h0000_0000;
      rsp_valid_r    <= 1'b0;
      timeout_err_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (go_s) begin
            is_load_r      <= bus.req_load;
            off_r          <= bus.req_addr[1:0];
            ldsel_r        <= bus.req_ldsel;
            dmem_address_r <= {bus.req_addr[31:2], 2'b00};
            dmem_mbe_r     <= build_mbe(bus.req_load, bus.req_stfunct3,
                                        bus.req_addr[1:0]);
            dmem_wdata_r   <= bus.req_load ? 32'h0000_0000 :
                              build_wdata(bus.req_stfunct3, bus.req_wdata);
            dmem_read_r    <= bus.req_load & ~misalign_s;
            dmem_write_r   <= bus.req_store & ~misalign_s;
            if (misalign_s) begin
              load_data_r <= 32'h0000_0000;
            end
          end
        end
        ST_ACCESS: begin
          if (bus.dmem_resp) begin
            dmem_read_r  <= 1'b0;
            dmem_write_r <= 1'b0;
            if (is_load_r) begin
              load_data_r <= align_load(ldsel_r, off_r, bus.dmem_rdata);
            end
          end else if (timeout_s) begin
            dmem_read_r  <= 1'b0;
            dmem_write_r <= 1'b0;
            load_data_r  <= 32'h0000_0000;
          end
        end
        default: begin
          dmem_read_r  <= 1'b0;
          dmem_write_r <= 1'b0;
        end
      endcase
      rsp_valid_r   <= (state_next_s == ST_DONE);
      timeout_err_r <= timeout_s;
    end
  end

  // Stall is combinational in IDLE so the issuing cycle is already frozen.
  assign bus.stall        = go_s | (state_r == ST_ACCESS);
  assign bus.dmem_read    = dmem_read_r;
  assign bus.dmem_write   = dmem_write_r;
  assign bus.dmem_address = dmem_address_r;
  assign bus.dmem_wdata   = dmem_wdata_r;
  assign bus.dmem_mbe     = dmem_mbe_r;
  assign bus.rsp_valid    = rsp_valid_r;
  assign bus.load_data    = load_data_r;
  assign bus.timeout_err  = timeout_err_r;

endmodule

// File: tb/tb_mem_stage_dport.sv
// Directed self-checking bench for mem_stage_dport.
module tb_mem_stage_dport;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  // Observations collected by do_access
  int          o_stall;
  int          o_acc;
  int          o_rspcyc;
  logic        o_done;
  logic        o_wr;
  logic [31:0] o_addr;
  logic [31:0] o_wdata;
  logic [3:0]  o_mbe;
  logic [31:0] o_ld;
  logic        o_tmo;
  logic        o_mis;
  logic [31:0] exp_ld;

  mem_stage_dport_if bus_if ();

  mem_stage_dport #(.TIMEOUT_CYCLES(64), .CNT_W(7)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  // Present one request, answer after resp_after ACCESS cycles (0 = never),
  // and record what the port did until rsp_valid or a cycle budget runs out.
  task automatic do_access(input logic ld, input logic st, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [3:0] sel,
                           input logic [2:0] f3, input int resp_after,
                           input logic [31:0] rd);
    o_stall = 0; o_acc = 0; o_rspcyc = 0; o_done = 1'b0; o_wr = 1'b0;
    o_addr = 32'h0; o_wdata = 32'h0; o_mbe = 4'h0; o_ld = 32'h0;
    o_tmo = 1'b0; o_mis = 1'b0;
    @(posedge clk); #1;
    bus_if.req_valid = 1'b1; bus_if.req_load = ld; bus_if.req_store = st;
    bus_if.req_addr = addr; bus_if.req_wdata = wd; bus_if.req_ldsel = sel;
    bus_if.req_stfunct3 = f3;
    for (int c = 1; c <= 200; c++) begin
      #1;
      if (bus_if.stall) o_stall++;
      if (bus_if.dmem_read || bus_if.dmem_write) begin
        o_acc++;
        o_wr = bus_if.dmem_write;
        o_addr = bus_if.dmem_address;
        o_wdata = bus_if.dmem_wdata;
        o_mbe = bus_if.dmem_mbe;
        if (o_acc == resp_after) begin
          bus_if.dmem_resp = 1'b1;
          bus_if.dmem_rdata = rd;
        end
      end
      if (bus_if.rsp_valid) begin
        o_done = 1'b1; o_rspcyc = c; o_ld = bus_if.load_data;
        o_tmo = bus_if.timeout_err; o_mis = bus_if.misalign;
        break;
      end
      @(posedge clk); #1;
      bus_if.dmem_resp = 1'b0;
    end
    bus_if.req_valid = 1'b0; bus_if.req_load = 1'b0; bus_if.req_store = 1'b0;
    check("rsp_seen", 32'(o_done), 32'd1);
  endtask

  initial begin
    checks = 0; failures = 0; exp_ld = 32'h0;
    rst = 1'b0;
    bus_if.req_valid = 1'b0; bus_if.req_load = 1'b0; bus_if.req_store = 1'b0;
    bus_if.req_flush = 1'b0; bus_if.req_addr = 32'h0; bus_if.req_wdata = 32'h0;
    bus_if.req_ldsel = 4'h0; bus_if.req_stfunct3 = 3'b000;
    bus_if.dmem_resp = 1'b0; bus_if.dmem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_read", 32'(bus_if.dmem_read), 32'd0);
    check("rst_stall", 32'(bus_if.stall), 32'd0);
    check("rst_rsp", 32'(bus_if.rsp_valid), 32'd0);
    check("rst_ld", bus_if.load_data, 32'h0);
    check("rst_addr", bus_if.dmem_address, 32'h0);
    rst = 1'b1;

    // lw with response in the 3rd ACCESS cycle
    do_access(1'b1, 1'b0, 32'h100, 32'h0, 4'd3, 3'b010, 3, 32'hDEADBEEF);
    check("lw_addr", o_addr, 32'h100);
    check("lw_stall_cycles", 32'(o_stall), 32'd4);
    check("lw_acc_cycles", 32'(o_acc), 32'd3);
    check("lw_rsp_cycle", 32'(o_rspcyc), 32'd5);
    check("lw_mbe", 32'(o_mbe), 32'hF);
    check("lw_data", o_ld, 32'hDEADBEEF);
    check("lw_tmo", 32'(o_tmo), 32'd0);
    @(posedge clk); #1;
    check("lw_rsp_pulse", 32'(bus_if.rsp_valid), 32'd0);
    check("lw_data_held", bus_if.load_data, 32'hDEADBEEF);

    // Byte/half loads, response in the first ACCESS cycle
    do_access(1'b1, 1'b0, 32'h203, 32'h0, 4'd5, 3'b000, 1, 32'h80112233);
    check("lb_data", o_ld, 32'hFFFFFF80);
    check("lb_stall_cycles", 32'(o_stall), 32'd2);
    check("lb_rsp_cycle", 32'(o_rspcyc), 32'd3);
    check("lb_addr", o_addr, 32'h200);
    do_access(1'b1, 1'b0, 32'h203, 32'h0, 4'd6, 3'b000, 1, 32'h80112233);
    check("lbu_data", o_ld, 32'h00000080);
    do_access(1'b1, 1'b0, 32'h202, 32'h0, 4'd8, 3'b000, 1, 32'h80112233);
    check("lhu_data", o_ld, 32'h00008011);
    do_access(1'b1, 1'b0, 32'h202, 32'h0, 4'd7, 3'b000, 1, 32'h80112233);
    check("lh_data", o_ld, 32'hFFFF8011);
    do_access(1'b1, 1'b0, 32'h200, 32'h0, 4'd7, 3'b000, 1, 32'h80112233);
    check("lh_low_data", o_ld, 32'h00002233);
    exp_ld = 32'h00002233;

    // Stores: lanes, replication, load_data untouched
    do_access(1'b0, 1'b1, 32'h301, 32'h000000A5, 4'd0, 3'b000, 2, 32'h0);
    check("sb_write", 32'(o_wr), 32'd1);
    check("sb_mbe", 32'(o_mbe), 32'h2);
    check("sb_wdata", o_wdata, 32'hA5A5A5A5);
    check("sb_addr", o_addr, 32'h300);
    check("sb_ld_kept", o_ld, exp_ld);
    do_access(1'b0, 1'b1, 32'h302, 32'h00001234, 4'd0, 3'b001, 1, 32'h0);
    check("sh_mbe", 32'(o_mbe), 32'hC);
    check("sh_wdata", o_wdata, 32'h12341234);
    do_access(1'b0, 1'b1, 32'h304, 32'hCAFEF00D, 4'd0, 3'b010, 1, 32'h0);
    check("sw_mbe", 32'(o_mbe), 32'hF);
    check("sw_wdata", o_wdata, 32'hCAFEF00D);
    check("sw_addr", o_addr, 32'h304);
    check("sw_ld_kept", o_ld, exp_ld);

    // Watchdog: no response at all
    do_access(1'b1, 1'b0, 32'h500, 32'h0, 4'd3, 3'b010, 0, 32'h0);
    check("tmo_acc_cycles", 32'(o_acc), 32'd64);
    check("tmo_stall_cycles", 32'(o_stall), 32'd65);
    check("tmo_flag", 32'(o_tmo), 32'd1);
    check("tmo_data", o_ld, 32'h0);
    check("tmo_stall_done", 32'(bus_if.stall), 32'd0);
    @(posedge clk); #1;
    check("tmo_flag_pulse", 32'(bus_if.timeout_err), 32'd0);

    // Async reset in the middle of ACCESS, then a late response
    do_access(1'b1, 1'b0, 32'h600, 32'h0, 4'd3, 3'b010, 1, 32'h55AA55AA);
    check("pre_rst_data", o_ld, 32'h55AA55AA);
    @(posedge clk); #1;
    bus_if.req_valid = 1'b1; bus_if.req_load = 1'b1; bus_if.req_addr = 32'h700;
    bus_if.req_ldsel = 4'd3;
    @(posedge clk); #1;
    check("mid_read", 32'(bus_if.dmem_read), 32'd1);
    bus_if.req_valid = 1'b0; bus_if.req_load = 1'b0;
    rst = 1'b0;
    #1;
    check("arst_read", 32'(bus_if.dmem_read), 32'd0);
    check("arst_stall", 32'(bus_if.stall), 32'd0);
    check("arst_addr", bus_if.dmem_address, 32'h0);
    check("arst_ld", bus_if.load_data, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    bus_if.dmem_resp = 1'b1; bus_if.dmem_rdata = 32'h12345678;
    @(posedge clk); #1;
    bus_if.dmem_resp = 1'b0;
    check("late_resp_rsp", 32'(bus_if.rsp_valid), 32'd0);
    check("late_resp_ld", bus_if.load_data, 32'h0);
    @(posedge clk); #1;
    check("late_resp_rsp2", 32'(bus_if.rsp_valid), 32'd0);

    // Flushed and non-memory requests in IDLE
    bus_if.req_valid = 1'b1; bus_if.req_load = 1'b1; bus_if.req_flush = 1'b1;
    #1;
    check("flush_stall", 32'(bus_if.stall), 32'd0);
    @(posedge clk); #1;
    check("flush_read", 32'(bus_if.dmem_read), 32'd0);
    bus_if.req_flush = 1'b0; bus_if.req_load = 1'b0;
    #1;
    check("nonmem_stall", 32'(bus_if.stall), 32'd0);
    @(posedge clk); #1;
    check("nonmem_read", 32'(bus_if.dmem_read), 32'd0);
    check("nonmem_rsp", 32'(bus_if.rsp_valid), 32'd0);
    bus_if.req_valid = 1'b0;

    // Misaligned word load
    do_access(1'b1, 1'b0, 32'h102, 32'h0, 4'd3, 3'b010, 1, 32'h11223344);
`ifdef MISALIGN_CHK_EN
    check("mis_acc_cycles", 32'(o_acc), 32'd0);
    check("mis_rsp_cycle", 32'(o_rspcyc), 32'd2);
    check("mis_flag", 32'(o_mis), 32'd1);
    check("mis_data", o_ld, 32'h0);
`else
    check("unal_addr", o_addr, 32'h100);
    check("unal_acc_cycles", 32'(o_acc), 32'd1);
    check("unal_data", o_ld, 32'h11223344);
    check("unal_flag", 32'(o_mis), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
